// File: rtl/alu_sequencer_if.sv
// Request, ALU and response signal bundle between the sequencer and its environment.
interface alu_sequencer_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_load;
  logic [2:0]  i_req_op;
  logic [15:0] i_req_operand;
  logic [15:0] o_acc_alu_p;
  logic [15:0] o_acc_alu_q;
  logic [2:0]  o_alu_op;
  logic        o_alu_en;
  logic        o_c9;
  logic        o_c10;
  logic [15:0] i_br;
  logic [15:0] i_mr;
  logic [4:0]  i_flags;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [15:0] o_acc;
  logic [15:0] o_mr_hold;
  logic [4:0]  o_flags;
  logic [7:0]  o_op_count;

  modport slave (
    input  i_req_valid, i_req_load, i_req_op, i_req_operand,
    input  i_br, i_mr, i_flags, i_resp_ready,
    output o_req_ready, o_acc_alu_p, o_acc_alu_q, o_alu_op, o_alu_en,
    output o_c9, o_c10, o_resp_valid, o_acc, o_mr_hold, o_flags, o_op_count
  );

  modport master (
    output i_req_valid, i_req_load, i_req_op, i_req_operand,
    output i_br, i_mr, i_flags, i_resp_ready,
    input  o_req_ready, o_acc_alu_p, o_acc_alu_q, o_alu_op, o_alu_en,
    input  o_c9, o_c10, o_resp_valid, o_acc, o_mr_hold, o_flags, o_op_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// Accumulator sequencer: issues one op to an external ALU, captures BR/MR/flags,
// and presents the result on a valid/ready response channel.
module alu_sequencer (
  input  logic            i_clk,
  input  logic            i_rst,
  alu_sequencer_if.slave  bus
);
  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 3;
  localparam int unsigned FW  = 5;
  localparam int unsigned CW  = 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]     state;
  logic [1:0]     state_next;
  logic [DW-1:0]  acc;
  logic [DW-1:0]  operand;
  logic [OPW-1:0] op;
  logic [DW-1:0]  mr_hold;
  logic [FW-1:0]  flags;
  logic [CW-1:0]  op_count;

  logic req_ready;
  logic alu_en;
  logic bus_en;
  logic resp_valid;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and state-decoded strobes
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    alu_en     = 1'b0;
    bus_en     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.i_req_valid) state_next = bus.i_req_load ? RESP : ISSUE;
      end
      ISSUE: begin
        alu_en     = 1'b1;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        bus_en     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (bus.i_resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: request latch on accept, ALU results on capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc      <= '0;
      operand  <= '0;
      op       <= '0;
      mr_hold  <= '0;
      flags    <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req_valid) begin
            op      <= bus.i_req_op;
            operand <= bus.i_req_operand;
            if (bus.i_req_load) acc <= bus.i_req_operand;
          end
        end
        CAPTURE: begin
          acc      <= bus.i_br;
          mr_hold  <= bus.i_mr;
          flags    <= bus.i_flags;
          op_count <= op_count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_alu_en     = alu_en;
  assign bus.o_c9         = bus_en;
  assign bus.o_c10        = bus_en;
  assign bus.o_resp_valid = resp_valid;
  assign bus.o_acc_alu_p  = acc;
  assign bus.o_acc_alu_q  = operand;
  assign bus.o_alu_op     = op;
  assign bus.o_acc        = acc;
  assign bus.o_mr_hold    = mr_hold;
  assign bus.o_flags      = flags;
  assign bus.o_op_count   = op_count;
endmodule
